alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Registered ALU execute stage with built-in opcode/opext decode and a
//  WIDTH-bit datapath. Single-cycle logic/arith ops; multi-cycle shift
//  (and optional multiply) sequenced by an FSM. Holds a PSR-style flag
//  register. Sits between register-file read and writeback, using a
//  valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH  16  operand/result width in bits (>=4)
//  CNT_W  5   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      operation presented
//  in_ready   out  1      unit accepts operation this cycle
//  opcode     in   4      primary opcode
//  opext      in   4      extension; selects op when opcode==4'b0000
//  a          in   WIDTH  operand A (destination register value)
//  b          in   WIDTH  operand B (source register or immediate)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  result     out  WIDTH  registered result
//  flags      out  5      {C,L,F,Z,N}, registered
//  busy       out  1      FSM in EXEC
// BEHAVIOUR
//  Decode: opcode 0101 add, 1001 sub, 0001 and, 0011 xor, 0010 or,
//   1011 cmp, 1101 mov(result=b). opcode 0000 -> same codes on opext,
//   plus opext 0100 lsh, opext 1110 mul (MUL_EN only). Any other
//   combination -> mov.
//  Reset: state IDLE, out_valid=0, result=0, flags=0, busy=0.
//  FSM IDLE/EXEC/HOLD. Accept = in_valid & in_ready.
//   in_ready = (IDLE) | (HOLD & out_ready). in_ready=0 in EXEC.
//   IDLE/HOLD + accept of single-cycle op -> HOLD; result valid the
//    cycle after accept (latency 1).
//   Accept of lsh/mul -> EXEC; result valid after the N cycles below.
//   EXEC done -> HOLD; out_valid=1.
//   HOLD & out_ready & !in_valid -> IDLE; out_valid falls next cycle.
//   HOLD & out_ready & in_valid -> new op accepted (back-to-back). A
//    single-cycle op keeps out_valid high with the new result.
//   HOLD & !out_ready: result and flags held stable.
//  Arithmetic: mod 2**WIDTH. add: C=carry-out, F=signed overflow,
//   Z=(result==0). sub: C=borrow (a<b unsigned), F=signed overflow,
//   Z=(result==0). cmp: result=a (unchanged); L=a<b unsigned,
//   N=a<b signed, Z=a==b; C and F cleared. All other ops leave flags.
//   Flags update in the same cycle as result.
//  lsh: amount s=b as signed. s>=0: logical left shift; s<0: logical
//   right shift by -s. |s| saturates to WIDTH (result 0). One bit per
//   EXEC cycle. N=max(|s|,1) cycles; s=0 -> result=a after 1 cycle.
//  mul: shift-add; low WIDTH bits of a*b (unsigned). N=WIDTH cycles.
//  reset asserted mid-EXEC/HOLD: operation dropped, reset values apply.
// CONFIGURATION
//  ALU_MUL_EN defined: opext 1110 (opcode 0000) = multi-cycle mul.
//  Undefined: mul hardware absent; opext 1110 decodes as mov.
// TESTING
//  addi a=16'h7FFF,b=1 -> after 1 cyc result=16'h8000, F=1,C=0,Z=0
//  R cmp a=16'hFFFF,b=1 -> result=16'hFFFF, L=0,N=1,Z=0,C=0,F=0;
//   following and leaves flags unchanged
//  lsh a=16'h0001,b=16'hFFFD(-3) -> result 0, 3 cycles busy;
//   b=4 on a=16'h0003 -> 16'h0030 after 4 cyc, in_ready=0 while busy
//  out_ready=0 for 5 cyc in HOLD -> result/flags stable, in_ready=0;
//   then out_ready=1 with queued sub -> accepted same cycle, no bubble
//  ALU_MUL_EN: mul 16'h0012*16'h0034 -> 16'h03A8 after 16 cyc;
//   without macro -> result=16'h0034 after 1 cyc
//  reset pulse mid-lsh -> out_valid=0, flags=0, in_ready=1 next cycle

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - operand/result handshake bundle for the ALU execute stage
interface alu_exec_unit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [3:0]       opext;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;
  logic             busy;

  modport master (
    output in_valid, opcode, opext, a, b, out_ready,
    input  in_ready, out_valid, result, flags, busy
  );

  modport slave (
    input  in_valid, opcode, opext, a, b, out_ready,
    output in_ready, out_valid, result, flags, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - registered ALU execute stage; ALU_MUL_EN adds a multi-cycle multiply
module alu_exec_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;
  typedef enum logic [3:0] {
    OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_OR, OP_CMP, OP_LSH, OP_MUL
  } op_t;

  // flag bit positions inside {C,L,F,Z,N}
  localparam int FC = 4;
  localparam int FL = 3;
  localparam int FF = 2;
  localparam int FZ = 1;
  localparam int FN = 0;

  localparam logic [WIDTH:0] WIDTH_EXT = (WIDTH + 1)'(WIDTH);

  state_t           state, state_nxt;
  op_t              op;
  logic             is_multi;
  logic             accept;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       flags_q;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_flags;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   mag;
  logic [WIDTH:0]   sat;
  logic [CNT_W-1:0] lsh_cnt;
  logic [WIDTH-1:0] acc, acc_next;
  logic [CNT_W-1:0] rem;
  logic             shl;
  logic             do_shift;
  logic             done;
`ifdef ALU_MUL_EN
  logic             mul_mode;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
`endif

  function automatic op_t decode_code(input logic [3:0] c);
    case (c)
      4'b0101: decode_code = OP_ADD;
      4'b1001: decode_code = OP_SUB;
      4'b0001: decode_code = OP_AND;
      4'b0011: decode_code = OP_XOR;
      4'b0010: decode_code = OP_OR;
      4'b1011: decode_code = OP_CMP;
      default: decode_code = OP_MOV;
    endcase
  endfunction

  // opcode 0000 defers to opext, which also carries the multi-cycle ops
  always_comb begin
    op = OP_MOV;
    if (bus.opcode != 4'b0000) begin
      op = decode_code(bus.opcode);
    end else begin
      op = decode_code(bus.opext);
      if (bus.opext == 4'b0100) op = OP_LSH;
`ifdef ALU_MUL_EN
      if (bus.opext == 4'b1110) op = OP_MUL;
`endif
    end
  end

  assign is_multi = (op == OP_LSH) || (op == OP_MUL);
  assign accept   = bus.in_valid && bus.in_ready;

  // single-cycle result and flag update; untouched flags carry over
  always_comb begin
    sum       = {1'b0, bus.a} + {1'b0, bus.b};
    diff      = {1'b0, bus.a} - {1'b0, bus.b};
    alu_res   = bus.b;
    alu_flags = flags_q;
    case (op)
      OP_ADD: begin
        alu_res       = sum[WIDTH-1:0];
        alu_flags[FC] = sum[WIDTH];
        alu_flags[FF] = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        alu_flags[FZ] = (sum[WIDTH-1:0] == '0);
      end
      OP_SUB: begin
        alu_res       = diff[WIDTH-1:0];
        alu_flags[FC] = diff[WIDTH];
        alu_flags[FF] = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
        alu_flags[FZ] = (diff[WIDTH-1:0] == '0);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_CMP: begin
        alu_res       = bus.a;
        alu_flags[FC] = 1'b0;
        alu_flags[FF] = 1'b0;
        alu_flags[FL] = (bus.a < bus.b);
        alu_flags[FN] = ($signed(bus.a) < $signed(bus.b));
        alu_flags[FZ] = (bus.a == bus.b);
      end
      default: alu_res = bus.b;
    endcase
  end

  // shift magnitude is computed one bit wider so -2**(WIDTH-1) does not overflow
  always_comb begin
    mag     = bus.b[WIDTH-1] ? -{1'b1, bus.b} : {1'b0, bus.b};
    sat     = (mag > WIDTH_EXT) ? WIDTH_EXT : mag;
    lsh_cnt = (sat == '0) ? CNT_W'(1) : CNT_W'(sat);
  end

  // one iteration of the running shift or shift-add multiply
  always_comb begin
    acc_next = acc;
    if (do_shift) acc_next = shl ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};
`ifdef ALU_MUL_EN
    if (mul_mode) acc_next = acc + (mplier[0] ? mcand : '0);
`endif
  end

  assign done = (rem == CNT_W'(1));

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state: single-cycle ops land in HOLD, multi-cycle ops pass through EXEC
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = is_multi ? S_EXEC : S_HOLD;
      S_EXEC: if (done) state_nxt = S_HOLD;
      S_HOLD: begin
        if (bus.out_ready) begin
          if (bus.in_valid) state_nxt = is_multi ? S_EXEC : S_HOLD;
          else              state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // handshake outputs decoded from the state
  always_comb begin
    bus.in_ready  = (state == S_IDLE) || ((state == S_HOLD) && bus.out_ready);
    bus.out_valid = (state == S_HOLD);
    bus.busy      = (state == S_EXEC);
  end

  // datapath: capture results on accept, iterate while executing, hold otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      flags_q  <= '0;
      acc      <= '0;
      rem      <= '0;
      shl      <= 1'b0;
      do_shift <= 1'b0;
`ifdef ALU_MUL_EN
      mul_mode <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
`endif
    end else if (accept) begin
      if (!is_multi) begin
        result_q <= alu_res;
        flags_q  <= alu_flags;
      end
      acc      <= bus.a;
      rem      <= lsh_cnt;
      shl      <= ~bus.b[WIDTH-1];
      do_shift <= (sat != '0);
`ifdef ALU_MUL_EN
      mul_mode <= (op == OP_MUL);
      mcand    <= bus.a;
      mplier   <= bus.b;
      if (op == OP_MUL) begin
        acc      <= '0;
        rem      <= CNT_W'(WIDTH);
        do_shift <= 1'b0;
      end
`endif
    end else if (state == S_EXEC) begin
      acc <= acc_next;
      rem <= rem - CNT_W'(1);
`ifdef ALU_MUL_EN
      mcand  <= {mcand[WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
`endif
      if (done) result_q <= acc_next;
    end
  end

  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule
